// File: rtl/exec_issuer.sv
// Execute-unit initiator: takes one decoded instruction, pulses the ALU, waits for
// completion and turns the result into a writeback / memory / redirect commit record.
package exec_issuer_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        jal;
        logic        jalr;
        logic        beq;
        logic        bne;
        logic        blt;
        logic        bge;
        logic        bltu;
        logic        bgeu;
        logic        lb;
        logic        lh;
        logic        lw;
        logic        lbu;
        logic        lhu;
        logic        sb;
        logic        sh;
        logic        sw;
    } instructions;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair;
endpackage

module exec_issuer
    import exec_issuer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  instructions       in_instr,
    input  regvpair           in_reg,
    input  logic [4:0]        in_rd,
    output logic              exe_enabled,
    output instructions       exe_instr,
    output regvpair           exe_reg,
    input  logic              exe_completed,
    input  logic [31:0]       exe_result,
    output logic              out_valid,
    output logic              out_wr_en,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_data,
    output logic              out_mem,
    output logic [31:0]       out_next_pc,
    output logic              out_redirect,
    output logic              err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;

    logic        is_branch;
    logic        is_mem;
    logic [31:0] pc_seq;
    logic [31:0] nxt_pc;

    // Gated by rstn so decode sees no ready while reset is held.
    assign in_ready = rstn && (state == S_IDLE);

    always_comb begin
        is_branch = exe_instr.beq | exe_instr.bne | exe_instr.blt |
                    exe_instr.bge | exe_instr.bltu | exe_instr.bgeu;
        is_mem    = exe_instr.lb | exe_instr.lh | exe_instr.lw | exe_instr.lbu |
                    exe_instr.lhu | exe_instr.sb | exe_instr.sh | exe_instr.sw;
        pc_seq    = exe_instr.pc + 32'd4;
        nxt_pc    = pc_seq;
        if (exe_instr.jal || (is_branch && exe_result[0]))
            nxt_pc = exe_instr.pc + exe_instr.imm;
        else if (exe_instr.jalr)
            nxt_pc = (exe_reg.rs1 + exe_instr.imm) & ~32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            exe_enabled  <= 1'b0;
            exe_instr    <= '0;
            exe_reg      <= '0;
            out_valid    <= 1'b0;
            out_wr_en    <= 1'b0;
            out_rd       <= '0;
            out_data     <= '0;
            out_mem      <= 1'b0;
            out_next_pc  <= '0;
            out_redirect <= 1'b0;
            err          <= 1'b0;
        end else begin
            exe_enabled  <= 1'b0;
            out_valid    <= 1'b0;
            out_wr_en    <= 1'b0;
            out_mem      <= 1'b0;
            out_redirect <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        exe_instr   <= in_instr;
                        exe_reg     <= in_reg;
                        rd_q        <= in_rd;
                        exe_enabled <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (exe_completed) begin
                        out_valid    <= 1'b1;
                        out_rd       <= rd_q;
                        out_data     <= exe_result;
                        out_wr_en    <= !(is_branch || is_mem) && (rd_q != 5'd0);
                        out_mem      <= is_mem;
                        out_next_pc  <= nxt_pc;
                        out_redirect <= (nxt_pc != pc_seq);
                        state        <= S_COMMIT;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule
